// File: rtl/dsi_packet_checker_if.sv
// Bus between the DSI lane byte deserializer / host logic and dsi_packet_checker.
// Valid semantics: a byte on d_i is consumed in every cycle with valid_i=1 (no back-pressure);
// start_i and cnt_clr_i are sampled with it. All checker outputs are registered pulses or held fields.
interface dsi_packet_checker_if #(
    parameter int g_cnt_width = 16
);
    logic [7:0]             d_i;
    logic                   valid_i;
    logic                   start_i;
    logic                   cnt_clr_i;
    logic                   hdr_valid_o;
    logic [5:0]             dt_o;
    logic [1:0]             vc_o;
    logic [15:0]            wc_o;
    logic                   long_o;
    logic [7:0]             pl_data_o;
    logic                   pl_valid_o;
    logic                   pl_last_o;
    logic                   pkt_done_o;
    logic                   crc_ok_o;
    logic                   ecc_err_o;
    logic                   trunc_err_o;
    logic [g_cnt_width-1:0] ecc_err_cnt_o;
    logic [g_cnt_width-1:0] crc_err_cnt_o;
    logic [2:0]             dbg_state_o;

    modport master (
        output d_i, valid_i, start_i, cnt_clr_i,
        input  hdr_valid_o, dt_o, vc_o, wc_o, long_o, pl_data_o, pl_valid_o, pl_last_o,
        input  pkt_done_o, crc_ok_o, ecc_err_o, trunc_err_o, ecc_err_cnt_o, crc_err_cnt_o,
        input  dbg_state_o
    );

    modport slave (
        input  d_i, valid_i, start_i, cnt_clr_i,
        output hdr_valid_o, dt_o, vc_o, wc_o, long_o, pl_data_o, pl_valid_o, pl_last_o,
        output pkt_done_o, crc_ok_o, ecc_err_o, trunc_err_o, ecc_err_cnt_o, crc_err_cnt_o,
        output dbg_state_o
    );
endinterface

// File: rtl/dsi_packet_checker.sv
// DSI receive packet parser: checks header ECC and long-packet CRC-16, forwards header
// fields and payload bytes, and keeps saturating ECC/CRC error counters.
module dsi_packet_checker #(
    parameter int g_cnt_width       = 16,
    parameter bit g_drop_on_ecc_err = 1'b1
) (
    input logic                 clk_i,
    input logic                 rst_n_i,
    dsi_packet_checker_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR     = 3'd1,
        PAYLOAD = 3'd2,
        CRC0    = 3'd3,
        CRC1    = 3'd4,
        DROP    = 3'd5
    } state_t;

    localparam logic [g_cnt_width-1:0] lp_cnt_one = {{(g_cnt_width-1){1'b0}}, 1'b1};

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [1:0]             r_hcnt;
    logic [7:0]             r_di;
    logic [7:0]             r_b1;
    logic [7:0]             r_b2;
    logic [7:0]             r_crc_lo;
    logic [15:0]            r_cnt;
    logic [15:0]            r_crc;
    logic                   r_hdr_valid;
    logic [7:0]             r_hdr_di;
    logic [15:0]            r_wc;
    logic                   r_long;
    logic [7:0]             r_pl_data;
    logic                   r_pl_valid;
    logic                   r_pl_last;
    logic                   r_pkt_done;
    logic                   r_crc_ok;
    logic                   r_ecc_err;
    logic                   r_trunc_err;
    logic [g_cnt_width-1:0] r_ecc_cnt;
    logic [g_cnt_width-1:0] r_crc_cnt;

    logic                   w_start;
    logic [23:0]            w_hdr;
    logic [5:0]             w_ecc;
    logic                   w_ecc_bad;
    logic                   w_long;
    logic [15:0]            w_wc;
    logic [15:0]            w_crc_next;
    logic                   w_hdr_valid;
    logic                   w_pkt_done;
    logic                   w_crc_ok;
    logic                   w_ecc_err;
    logic                   w_trunc_err;
    logic                   w_pl_valid;
    logic                   w_pl_last;
    logic                   w_ecc_inc;
    logic                   w_crc_inc;
    logic                   w_crc_init;
    logic                   w_cap_lo;

    // Reflected CRC-16 (poly 0x8408), one byte folded in LSB first.
    function automatic logic [15:0] f_crc_byte(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c >> 1) ^ (((c[0] ^ d[i]) == 1'b1) ? 16'h8408 : 16'h0000);
        end
        return c;
    endfunction

    assign w_start    = bus.valid_i & bus.start_i;
    assign w_hdr      = {r_b2, r_b1, r_di};
    assign w_long     = r_di[3] & (|r_di[2:0]);
    assign w_wc       = {r_b2, r_b1};
    assign w_crc_next = f_crc_byte(r_crc, bus.d_i);

    assign w_ecc[0] = w_hdr[0] ^ w_hdr[1] ^ w_hdr[2] ^ w_hdr[4] ^ w_hdr[5] ^ w_hdr[7] ^ w_hdr[10] ^
                      w_hdr[11] ^ w_hdr[13] ^ w_hdr[16] ^ w_hdr[20] ^ w_hdr[21] ^ w_hdr[22] ^ w_hdr[23];
    assign w_ecc[1] = w_hdr[0] ^ w_hdr[1] ^ w_hdr[3] ^ w_hdr[4] ^ w_hdr[6] ^ w_hdr[8] ^ w_hdr[10] ^
                      w_hdr[12] ^ w_hdr[14] ^ w_hdr[17] ^ w_hdr[20] ^ w_hdr[21] ^ w_hdr[22] ^ w_hdr[23];
    assign w_ecc[2] = w_hdr[0] ^ w_hdr[2] ^ w_hdr[3] ^ w_hdr[5] ^ w_hdr[6] ^ w_hdr[9] ^ w_hdr[11] ^
                      w_hdr[12] ^ w_hdr[15] ^ w_hdr[18] ^ w_hdr[20] ^ w_hdr[21] ^ w_hdr[22];
    assign w_ecc[3] = w_hdr[1] ^ w_hdr[2] ^ w_hdr[3] ^ w_hdr[7] ^ w_hdr[8] ^ w_hdr[9] ^ w_hdr[13] ^
                      w_hdr[14] ^ w_hdr[15] ^ w_hdr[19] ^ w_hdr[20] ^ w_hdr[21] ^ w_hdr[23];
    assign w_ecc[4] = w_hdr[4] ^ w_hdr[5] ^ w_hdr[6] ^ w_hdr[7] ^ w_hdr[8] ^ w_hdr[9] ^ w_hdr[16] ^
                      w_hdr[17] ^ w_hdr[18] ^ w_hdr[19] ^ w_hdr[20] ^ w_hdr[22] ^ w_hdr[23];
    assign w_ecc[5] = w_hdr[10] ^ w_hdr[11] ^ w_hdr[12] ^ w_hdr[13] ^ w_hdr[14] ^ w_hdr[15] ^ w_hdr[16] ^
                      w_hdr[17] ^ w_hdr[18] ^ w_hdr[19] ^ w_hdr[21] ^ w_hdr[22] ^ w_hdr[23];
    assign w_ecc_bad = (w_ecc != bus.d_i[5:0]) || (bus.d_i[7:6] != 2'b00);

    // A qualified start always wins: it aborts whatever packet is open and restarts the header.
    always_comb begin
        w_state_nxt = r_state;
        w_hdr_valid = 1'b0;
        w_pkt_done  = 1'b0;
        w_crc_ok    = 1'b0;
        w_ecc_err   = 1'b0;
        w_trunc_err = 1'b0;
        w_pl_valid  = 1'b0;
        w_pl_last   = 1'b0;
        w_ecc_inc   = 1'b0;
        w_crc_inc   = 1'b0;
        w_crc_init  = 1'b0;
        w_cap_lo    = 1'b0;
        if (w_start) begin
            w_state_nxt = HDR;
            w_crc_init  = 1'b1;
            w_trunc_err = (r_state == HDR) || (r_state == PAYLOAD) ||
                          (r_state == CRC0) || (r_state == CRC1);
        end else if (bus.valid_i) begin
            case (r_state)
                HDR: begin
                    if (r_hcnt == 2'd3) begin
                        w_ecc_err = w_ecc_bad;
                        w_ecc_inc = w_ecc_bad;
                        if (w_ecc_bad && g_drop_on_ecc_err) begin
                            w_state_nxt = DROP;
                        end else begin
                            w_hdr_valid = 1'b1;
                            if (!w_long) begin
                                w_pkt_done  = 1'b1;
                                w_crc_ok    = 1'b1;
                                w_state_nxt = IDLE;
                            end else if (w_wc == 16'd0) begin
                                w_state_nxt = CRC0;
                            end else begin
                                w_state_nxt = PAYLOAD;
                            end
                        end
                    end
                end
                PAYLOAD: begin
                    w_pl_valid = 1'b1;
                    if (r_cnt == 16'd1) begin
                        w_pl_last   = 1'b1;
                        w_state_nxt = CRC0;
                    end
                end
                CRC0: begin
                    w_cap_lo    = 1'b1;
                    w_state_nxt = CRC1;
                end
                CRC1: begin
                    w_pkt_done  = 1'b1;
                    w_crc_ok    = ({bus.d_i, r_crc_lo} == r_crc);
                    w_crc_inc   = ({bus.d_i, r_crc_lo} != r_crc);
                    w_crc_init  = 1'b1;
                    w_state_nxt = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= IDLE;
            r_hcnt      <= 2'd0;
            r_di        <= 8'h00;
            r_b1        <= 8'h00;
            r_b2        <= 8'h00;
            r_crc_lo    <= 8'h00;
            r_cnt       <= 16'h0000;
            r_crc       <= 16'hFFFF;
            r_hdr_valid <= 1'b0;
            r_hdr_di    <= 8'h00;
            r_wc        <= 16'h0000;
            r_long      <= 1'b0;
            r_pl_data   <= 8'h00;
            r_pl_valid  <= 1'b0;
            r_pl_last   <= 1'b0;
            r_pkt_done  <= 1'b0;
            r_crc_ok    <= 1'b0;
            r_ecc_err   <= 1'b0;
            r_trunc_err <= 1'b0;
            r_ecc_cnt   <= '0;
            r_crc_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_di   <= bus.d_i;
                r_hcnt <= 2'd1;
            end else if (bus.valid_i && (r_state == HDR)) begin
                if (r_hcnt == 2'd1) r_b1 <= bus.d_i;
                if (r_hcnt == 2'd2) r_b2 <= bus.d_i;
                r_hcnt <= r_hcnt + 2'd1;
            end
            if (w_cap_lo) r_crc_lo <= bus.d_i;
            if (w_hdr_valid) begin
                r_hdr_di <= r_di;
                r_wc     <= w_wc;
                r_long   <= w_long;
                r_cnt    <= w_wc;
            end else if (w_pl_valid) begin
                r_cnt <= r_cnt - 16'd1;
            end
            if (w_crc_init) begin
                r_crc <= 16'hFFFF;
            end else if (w_pl_valid) begin
                r_crc <= w_crc_next;
            end
            if (w_pl_valid) r_pl_data <= bus.d_i;
            r_hdr_valid <= w_hdr_valid;
            r_pl_valid  <= w_pl_valid;
            r_pl_last   <= w_pl_last;
            r_pkt_done  <= w_pkt_done;
            r_crc_ok    <= w_crc_ok;
            r_ecc_err   <= w_ecc_err;
            r_trunc_err <= w_trunc_err;
            if (bus.cnt_clr_i) begin
                r_ecc_cnt <= '0;
                r_crc_cnt <= '0;
            end else begin
                if (w_ecc_inc && (r_ecc_cnt != '1)) r_ecc_cnt <= r_ecc_cnt + lp_cnt_one;
                if (w_crc_inc && (r_crc_cnt != '1)) r_crc_cnt <= r_crc_cnt + lp_cnt_one;
            end
        end
    end

    assign bus.hdr_valid_o   = r_hdr_valid;
    assign bus.dt_o          = r_hdr_di[5:0];
    assign bus.vc_o          = r_hdr_di[7:6];
    assign bus.wc_o          = r_wc;
    assign bus.long_o        = r_long;
    assign bus.pl_data_o     = r_pl_data;
    assign bus.pl_valid_o    = r_pl_valid;
    assign bus.pl_last_o     = r_pl_last;
    assign bus.pkt_done_o    = r_pkt_done;
    assign bus.crc_ok_o      = r_crc_ok;
    assign bus.ecc_err_o     = r_ecc_err;
    assign bus.trunc_err_o   = r_trunc_err;
    assign bus.ecc_err_cnt_o = r_ecc_cnt;
    assign bus.crc_err_cnt_o = r_crc_cnt;
    assign bus.dbg_state_o   = r_state;
endmodule

// File: tb/tb_dsi_packet_checker.sv
// Bench for dsi_packet_checker: header vector table, long-packet/CRC sequences, truncation,
// counter saturation/clear and random valid gaps, all checked through an expected-event queue.
module tb_dsi_packet_checker;
    localparam int lp_cnt_w = 4;

    logic clk_i = 1'b0;
    logic rst_n_i;
    always #5 clk_i = ~clk_i;

    dsi_packet_checker_if #(.g_cnt_width(lp_cnt_w)) bus ();

    dsi_packet_checker #(
        .g_cnt_width       (lp_cnt_w),
        .g_drop_on_ecc_err (1'b1)
    ) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus)
    );

    typedef struct packed {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  b3;
        logic        exp_err;
        logic [1:0]  exp_vc;
        logic [5:0]  exp_dt;
        logic [15:0] exp_wc;
    } vec_t;

    vec_t                vecs [8];
    logic [31:0]         exp_q [$];
    logic [7:0]          pl_buf [0:31];
    logic [lp_cnt_w-1:0] exp_ecc_cnt;
    logic [lp_cnt_w-1:0] exp_crc_cnt;
    int                  checks;
    int                  errors;
    bit                  gaps_en;

    // Event encoding shared by the expectation side and the monitor.
    function automatic logic [31:0] ev_hdr(input logic [7:0] di, input logic [15:0] wc, input logic lng);
        return {4'd1, 3'd0, lng, wc, di};
    endfunction
    function automatic logic [31:0] ev_pl(input logic [7:0] d, input logic last);
        return {4'd2, 19'd0, last, d};
    endfunction
    function automatic logic [31:0] ev_done(input logic ok);
        return {4'd3, 27'd0, ok};
    endfunction
    function automatic logic [31:0] ev_ecc();
        return {4'd4, 28'd0};
    endfunction
    function automatic logic [31:0] ev_trunc();
        return {4'd5, 28'd0};
    endfunction

    function automatic logic [5:0] f_ecc(input logic [23:0] d);
        return {^(d & 24'hEFFC00), ^(d & 24'hDF03F0), ^(d & 24'hB8E38E),
                ^(d & 24'h749A6D), ^(d & 24'hF2555B), ^(d & 24'hF12CB7)};
    endfunction

    function automatic logic [15:0] f_crc(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        c = crc ^ {8'h00, d};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        return c;
    endfunction

    function automatic logic [15:0] crc_buf(input int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int k = 0; k < n; k++) c = f_crc(c, pl_buf[k]);
        return c;
    endfunction

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_check(input string name, input logic [31:0] act);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: got event %h, expected no event", name, act);
        end else begin
            e = exp_q.pop_front();
            if (e !== act) begin
                errors++;
                $display("FAIL %s: got event %h, expected %h", name, act, e);
            end
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_n_i === 1'b1) begin
            if (bus.ecc_err_o)   sb_check("ecc_err", ev_ecc());
            if (bus.trunc_err_o) sb_check("trunc_err", ev_trunc());
            if (bus.hdr_valid_o) sb_check("hdr", ev_hdr({bus.vc_o, bus.dt_o}, bus.wc_o, bus.long_o));
            if (bus.pl_valid_o)  sb_check("payload", ev_pl(bus.pl_data_o, bus.pl_last_o));
            if (bus.pkt_done_o)  sb_check("pkt_done", ev_done(bus.crc_ok_o));
        end
    end

    task automatic drive_byte(input logic [7:0] b, input logic st, input logic clr);
        int n;
        if (gaps_en) begin
            n = int'($urandom_range(0, 2));
            repeat (n) begin
                bus.d_i     = 8'($urandom_range(0, 255));
                bus.start_i = 1'($urandom_range(0, 1));
                @(posedge clk_i); #1;
            end
        end
        bus.d_i       = b;
        bus.valid_i   = 1'b1;
        bus.start_i   = st;
        bus.cnt_clr_i = clr;
        @(posedge clk_i); #1;
        bus.valid_i   = 1'b0;
        bus.start_i   = 1'b0;
        bus.cnt_clr_i = 1'b0;
        bus.d_i       = 8'h00;
    endtask

    task automatic bump_ecc(input logic clr);
        if (clr) exp_ecc_cnt = '0;
        else if (exp_ecc_cnt != '1) exp_ecc_cnt = exp_ecc_cnt + 1'b1;
    endtask

    task automatic send_short(input logic [7:0] b0, b1, b2, b3, input logic clr);
        if ((f_ecc({b2, b1, b0}) != b3[5:0]) || (b3[7:6] != 2'b00)) begin
            exp_q.push_back(ev_ecc());
            bump_ecc(clr);
        end else begin
            exp_q.push_back(ev_hdr(b0, {b2, b1}, 1'b0));
            exp_q.push_back(ev_done(1'b1));
            if (clr) exp_ecc_cnt = '0;
        end
        drive_byte(b0, 1'b1, 1'b0);
        drive_byte(b1, 1'b0, 1'b0);
        drive_byte(b2, 1'b0, 1'b0);
        drive_byte(b3, 1'b0, clr);
    endtask

    task automatic send_long_partial(input logic [7:0] di, input logic [15:0] wc, input int n_pl);
        exp_q.push_back(ev_hdr(di, wc, 1'b1));
        drive_byte(di, 1'b1, 1'b0);
        drive_byte(wc[7:0], 1'b0, 1'b0);
        drive_byte(wc[15:8], 1'b0, 1'b0);
        drive_byte({2'b00, f_ecc({wc, di})}, 1'b0, 1'b0);
        for (int k = 0; k < n_pl; k++) begin
            exp_q.push_back(ev_pl(pl_buf[k], k == (int'(wc) - 1)));
            drive_byte(pl_buf[k], 1'b0, 1'b0);
        end
    endtask

    task automatic send_long(input logic [7:0] di, input int n, input logic [7:0] lo, hi, input logic exp_ok);
        send_long_partial(di, 16'(n), n);
        exp_q.push_back(ev_done(exp_ok));
        if (!exp_ok && (exp_crc_cnt != '1)) exp_crc_cnt = exp_crc_cnt + 1'b1;
        drive_byte(lo, 1'b0, 1'b0);
        drive_byte(hi, 1'b0, 1'b0);
    endtask

    task automatic drain(input string name);
        repeat (3) @(posedge clk_i);
        #1;
        check_eq({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic check_cnts(input string name);
        check_eq({name, "_ecc_cnt"}, 64'(bus.ecc_err_cnt_o), 64'(exp_ecc_cnt));
        check_eq({name, "_crc_cnt"}, 64'(bus.crc_err_cnt_o), 64'(exp_crc_cnt));
    endtask

    task automatic load_ascii();
        for (int k = 0; k < 9; k++) pl_buf[k] = 8'h31 + 8'(k);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] c;
        logic [7:0]  di;
        int          n;
        checks        = 0;
        errors        = 0;
        gaps_en       = 1'b0;
        exp_ecc_cnt   = '0;
        exp_crc_cnt   = '0;
        bus.d_i       = 8'h00;
        bus.valid_i   = 1'b0;
        bus.start_i   = 1'b0;
        bus.cnt_clr_i = 1'b0;
        rst_n_i       = 1'b0;

        vecs[0] = '{8'h15, 8'h29, 8'h00, 8'h0F, 1'b0, 2'd0, 6'h15, 16'h0029};
        vecs[1] = '{8'h15, 8'h29, 8'h00, 8'h0E, 1'b1, 2'd0, 6'h15, 16'h0029};
        vecs[2] = '{8'h05, 8'h00, 8'h00, 8'h0A, 1'b0, 2'd0, 6'h05, 16'h0000};
        vecs[3] = '{8'h81, 8'h00, 8'h00, 8'h1E, 1'b0, 2'd2, 6'h01, 16'h0000};
        vecs[4] = '{8'h15, 8'h29, 8'h00, 8'h4F, 1'b1, 2'd0, 6'h15, 16'h0029};
        vecs[5] = '{8'h08, 8'h00, 8'h00, 8'h0E, 1'b0, 2'd0, 6'h08, 16'h0000};
        vecs[6] = '{8'h15, 8'h00, 8'h80, 8'h22, 1'b0, 2'd0, 6'h15, 16'h8000};
        vecs[7] = '{8'h15, 8'h28, 8'h00, 8'h0F, 1'b1, 2'd0, 6'h15, 16'h0028};

        repeat (3) @(posedge clk_i);
        #1;
        check_eq("reset_pulses", 64'({bus.hdr_valid_o, bus.pl_valid_o, bus.pl_last_o, bus.pkt_done_o,
                                      bus.crc_ok_o, bus.ecc_err_o, bus.trunc_err_o}), 64'd0);
        check_eq("reset_fields", 64'({bus.dt_o, bus.vc_o, bus.wc_o, bus.long_o, bus.pl_data_o}), 64'd0);
        check_cnts("reset");
        check_eq("reset_state", 64'(bus.dbg_state_o), 64'd0);
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;

        load_ascii();
        send_long(8'h39, 9, 8'h91, 8'h6F, 1'b1);
        drain("long_ok");
        check_cnts("long_ok");

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].exp_err) begin
                exp_q.push_back(ev_ecc());
                bump_ecc(1'b0);
            end else begin
                exp_q.push_back(ev_hdr({vecs[i].exp_vc, vecs[i].exp_dt}, vecs[i].exp_wc, 1'b0));
                exp_q.push_back(ev_done(1'b1));
            end
            drive_byte(vecs[i].b0, 1'b1, 1'b0);
            drive_byte(vecs[i].b1, 1'b0, 1'b0);
            drive_byte(vecs[i].b2, 1'b0, 1'b0);
            drive_byte(vecs[i].b3, 1'b0, 1'b0);
            drain($sformatf("vec%0d", i));
        end
        check_cnts("vec_table");

        send_long(8'h39, 9, 8'h91, 8'h6E, 1'b0);
        drain("long_bad_crc");
        check_cnts("long_bad_crc");
        send_long(8'h39, 0, 8'hFF, 8'hFF, 1'b1);
        drain("long_wc0");

        for (int r = 0; r < 4; r++) begin
            n  = int'($urandom_range(1, 24));
            di = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b1, 3'($urandom_range(1, 7))};
            for (int k = 0; k < n; k++) pl_buf[k] = 8'($urandom_range(0, 255));
            c = crc_buf(n);
            if (r % 2 == 1) c[15:8] = c[15:8] ^ (8'h01 << $urandom_range(0, 7));
            send_long(di, n, c[7:0], c[15:8], r % 2 == 0);
            drain($sformatf("long_rand%0d", r));
        end
        check_cnts("long_rand");

        load_ascii();
        send_long_partial(8'h39, 16'd9, 4);
        exp_q.push_back(ev_trunc());
        send_short(8'h15, 8'h29, 8'h00, 8'h0F, 1'b0);
        drain("trunc_payload");

        exp_q.push_back(ev_trunc());
        drive_byte(8'h39, 1'b1, 1'b0);
        drive_byte(8'h09, 1'b0, 1'b0);
        send_short(8'h05, 8'h00, 8'h00, 8'h0A, 1'b0);
        drain("trunc_hdr");

        send_long_partial(8'h39, 16'd9, 9);
        exp_q.push_back(ev_trunc());
        send_short(8'h15, 8'h29, 8'h00, 8'h0F, 1'b0);
        drain("trunc_crc0");

        send_long_partial(8'h39, 16'd9, 9);
        drive_byte(8'h91, 1'b0, 1'b0);
        exp_q.push_back(ev_trunc());
        send_short(8'h15, 8'h29, 8'h00, 8'h0F, 1'b0);
        drain("trunc_crc1");
        load_ascii();
        send_long(8'h39, 9, 8'h91, 8'h6F, 1'b1);
        drain("after_trunc_crc");

        for (int k = 0; k < 5; k++) pl_buf[k] = 8'($urandom_range(0, 255));
        send_long_partial(8'h29, 16'hFFFF, 5);
        exp_q.push_back(ev_trunc());
        send_short(8'h81, 8'h00, 8'h00, 8'h1E, 1'b0);
        drain("wc_ffff");

        gaps_en = 1'b1;
        load_ascii();
        send_long(8'h39, 9, 8'h91, 8'h6F, 1'b1);
        send_short(8'h15, 8'h29, 8'h00, 8'h0E, 1'b0);
        send_short(8'h15, 8'h00, 8'h80, 8'h22, 1'b0);
        send_long(8'h39, 0, 8'hFF, 8'hFF, 1'b1);
        drain("gaps");
        check_cnts("gaps");
        gaps_en = 1'b0;

        bus.cnt_clr_i = 1'b1;
        @(posedge clk_i); #1;
        bus.cnt_clr_i = 1'b0;
        exp_ecc_cnt = '0;
        exp_crc_cnt = '0;
        check_cnts("clear");
        for (int i = 0; i < (1 << lp_cnt_w) + 3; i++) send_short(8'h15, 8'h29, 8'h00, 8'h0E, 1'b0);
        drain("saturate");
        check_eq("ecc_cnt_saturated", 64'(bus.ecc_err_cnt_o), 64'(4'hF));
        check_cnts("saturate");
        send_short(8'h15, 8'h29, 8'h00, 8'h4E, 1'b1);
        drain("clr_with_err");
        check_cnts("clr_with_err");
        send_short(8'h15, 8'h29, 8'h00, 8'h0E, 1'b0);
        drain("err_after_clr");
        check_cnts("err_after_clr");

        load_ascii();
        send_long_partial(8'h39, 16'd9, 3);
        @(posedge clk_i); #1;
        rst_n_i = 1'b0;
        #1;
        exp_ecc_cnt = '0;
        exp_crc_cnt = '0;
        check_eq("midreset_state", 64'(bus.dbg_state_o), 64'd0);
        check_eq("midreset_pulses", 64'({bus.hdr_valid_o, bus.pl_valid_o, bus.pl_last_o, bus.pkt_done_o,
                                         bus.crc_ok_o, bus.ecc_err_o, bus.trunc_err_o}), 64'd0);
        check_cnts("midreset");
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        drain("midreset");
        send_short(8'h15, 8'h29, 8'h00, 8'h0F, 1'b0);
        drain("after_midreset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
